// File: rtl/alu_pkg.sv
// Shared constants for the ALU result stage: datapath widths, opcode tags,
// flag bit positions, skid buffer states and the flag helper.
package alu_pkg;

    localparam int ALU_WIDTH = 16;
    localparam int ALU_OPW   = 3;

    localparam logic [ALU_OPW-1:0] OP_NAND = 3'd0;
    localparam logic [ALU_OPW-1:0] OP_AND  = 3'd1;
    localparam logic [ALU_OPW-1:0] OP_OR   = 3'd2;
    localparam logic [ALU_OPW-1:0] OP_XOR  = 3'd3;
    localparam logic [ALU_OPW-1:0] OP_NOR  = 3'd4;
    localparam logic [ALU_OPW-1:0] OP_NOT  = 3'd5;

    localparam int FLG_ZERO = 0;
    localparam int FLG_NEG  = 1;
    localparam int FLG_PAR  = 2;
    localparam int FLG_W    = 3;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_t;

    // Result entry as it travels through the stage (default widths).
    typedef struct packed {
        logic [ALU_WIDTH-1:0] result;
        logic [ALU_OPW-1:0]   op;
        logic [FLG_W-1:0]     flags;
    } alu_entry_t;

endpackage

// File: rtl/alu_skid_buffer.sv
// Generic two-entry valid/ready buffer. in_ready comes straight from a flop,
// so there is no combinational path from out_ready back to the producer.
module alu_skid_buffer
    import alu_pkg::*;
#(
    parameter int DW = 22
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    skid_state_t   state_q, state_d;
    logic [DW-1:0] main_q, skid_q;
    logic          in_ready_q;
    logic          in_xfer, out_xfer;
    logic          load_main, load_skid, skid_to_main;

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != SKID_EMPTY);
    assign out_data  = main_q;
    assign in_xfer   = in_valid & in_ready_q;
    assign out_xfer  = out_valid & out_ready;

    // Next-state and datapath steering; the only way into TWO is an input
    // arriving while main is stalled, and TWO blocks further input.
    always_comb begin
        state_d      = state_q;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        unique case (state_q)
            SKID_EMPTY: begin
                if (in_xfer) begin
                    load_main = 1'b1;
                    state_d   = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (in_xfer && out_xfer) begin
                    load_main = 1'b1;
                end else if (in_xfer) begin
                    load_skid = 1'b1;
                    state_d   = SKID_TWO;
                end else if (out_xfer) begin
                    state_d   = SKID_EMPTY;
                end
            end
            SKID_TWO: begin
                if (out_xfer) begin
                    skid_to_main = 1'b1;
                    state_d      = SKID_ONE;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
    end

    // State register and registered in_ready (low only while both entries are full).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SKID_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != SKID_TWO);
        end
    end

    // Entry storage; main is held untouched whenever the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main)         main_q <= in_data;
            else if (skid_to_main) main_q <= skid_q;
            if (load_skid)         skid_q <= in_data;
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered output stage behind the bitwise logic units. Tags each result
// with {parity, neg, zero} at capture and buffers it in a 2-entry skid buffer.
// Optional accepted-result counter enabled by macro ALU_RESULT_STATS_EN.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int OPW   = ALU_OPW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [OPW-1:0]   in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [OPW-1:0]   out_op,
    output logic [2:0]       out_flags,
    output logic [15:0]      acc_count
);

    localparam int DW = WIDTH + OPW + FLG_W;

    logic [FLG_W-1:0] in_flags;
    logic [DW-1:0]    in_data, out_data;

    // Flags are derived from the incoming result so they travel with the entry.
    always_comb begin
        in_flags           = '0;
        in_flags[FLG_ZERO] = (in_result == '0);
        in_flags[FLG_NEG]  = in_result[WIDTH-1];
        in_flags[FLG_PAR]  = ^in_result;
    end

    assign in_data = {in_result, in_op, in_flags};
    assign {out_result, out_op, out_flags} = out_data;

    alu_skid_buffer #(.DW(DW)) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

`ifdef ALU_RESULT_STATS_EN
    logic [15:0] acc_q;

    // Count every accepted result; wraps naturally, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   acc_q <= '0;
        else if (in_valid && in_ready) acc_q <= acc_q + 16'd1;
    end

    assign acc_count = acc_q;
`else
    assign acc_count = '0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: reset, single results, backpressure,
// streaming, asynchronous reset with entries held, and the accept counter.
module tb_alu_result_stage;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_result;
    logic [2:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [2:0]  out_op;
    logic [2:0]  out_flags;
    logic [15:0] acc_count;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    alu_result_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_result (in_result),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_op    (out_op),
        .out_flags (out_flags),
        .acc_count (acc_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance past the next rising edge and settle.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_acc;
        int n_stats;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_result = '0;
        in_op     = '0;
        out_ready = 1'b0;

        // Reset
        cyc(); cyc();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready",  in_ready, 1);
        check("rst_flags",     out_flags, 0);
        check("rst_result",    out_result, 0);
        check("rst_op",        out_op, 0);
        check("rst_acc",       acc_count, 0);
        rst_n = 1'b1;
        cyc();
        check("post_rst_in_ready",  in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);

        // Single results with out_ready=1
        n_acc     = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1; in_result = 16'hFFFF; in_op = OP_NAND;
        cyc(); n_acc++;
        check("s1_valid",  out_valid, 1);
        check("s1_result", out_result, 16'hFFFF);
        check("s1_flags",  out_flags, 3'b010);
        check("s1_op",     out_op, OP_NAND);
        in_result = 16'h0000; in_op = OP_AND;
        cyc(); n_acc++;
        in_valid = 1'b0;
        check("s2_valid",  out_valid, 1);
        check("s2_result", out_result, 16'h0000);
        check("s2_flags",  out_flags, 3'b001);
        check("s2_op",     out_op, OP_AND);
        cyc();
        check("s2_drain",  out_valid, 0);

        // Backpressure fills both entries
        out_ready = 1'b0;
        in_valid  = 1'b1; in_result = 16'h1234; in_op = OP_OR;
        cyc(); n_acc++;
        check("bp1_in_ready", in_ready, 1);
        check("bp1_result",   out_result, 16'h1234);
        in_result = 16'h00F0; in_op = OP_XOR;
        cyc(); n_acc++;
        in_valid = 1'b0;
        check("bp2_in_ready", in_ready, 0);
        check("bp2_result",   out_result, 16'h1234);
        check("bp2_flags",    out_flags, 3'b100);
        cyc();
        check("bp_hold_valid",  out_valid, 1);
        check("bp_hold_result", out_result, 16'h1234);
        check("bp_hold_op",     out_op, OP_OR);
        out_ready = 1'b1;
        cyc();
        check("bp3_valid",    out_valid, 1);
        check("bp3_result",   out_result, 16'h00F0);
        check("bp3_flags",    out_flags, 3'b000);
        check("bp3_op",       out_op, OP_XOR);
        check("bp3_in_ready", in_ready, 1);
        cyc();
        check("bp_drain", out_valid, 0);

        // Streaming at full rate
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_result = 16'h0100 + 16'(i);
            in_op     = 3'(i % 6);
            cyc(); n_acc++;
            check("st_in_ready", in_ready, 1);
            check("st_valid",    out_valid, 1);
            check("st_result",   out_result, 32'h0100 + i);
        end
        in_valid = 1'b0;
        cyc();
        check("st_drain", out_valid, 0);
`ifdef ALU_RESULT_STATS_EN
        check("st_acc", acc_count, n_acc);
`else
        check("st_acc", acc_count, 0);
`endif

        // Asynchronous reset with two entries held
        out_ready = 1'b0;
        in_valid  = 1'b1; in_result = 16'hAAAA; in_op = OP_NOR;
        cyc();
        in_result = 16'h5555; in_op = OP_NOT;
        cyc();
        in_valid = 1'b0;
        check("mr_full", in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check("mr_out_valid", out_valid, 0);
        check("mr_in_ready",  in_ready, 1);
        check("mr_result",    out_result, 0);
        check("mr_acc",       acc_count, 0);
        cyc();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("mr_no_ghost", out_valid, 0);
        end

        // Accept counter
`ifdef ALU_RESULT_STATS_EN
        n_stats = 70000;
`else
        n_stats = 300;
`endif
        in_valid = 1'b1;
        for (int i = 0; i < n_stats; i++) begin
            in_result = 16'(i);
            cyc();
        end
        in_valid = 1'b0;
        check("cnt_last_result", out_result, 32'(16'(n_stats - 1)));
`ifdef ALU_RESULT_STATS_EN
        check("cnt_acc", acc_count, 4464);
`else
        check("cnt_acc", acc_count, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
